// File: rtl/dualport_ram_arb.sv
// Dual-port word RAM with per-cycle collision arbitration.
// Optional write-to-read forwarding: define DUALPORT_RAM_ARB_FWD_EN.
module dualport_ram_arb #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic              rd_a,
  input  logic              rd_b,
  input  logic              wr_a,
  input  logic              wr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic              rvalid_a,
  output logic              rvalid_b,
  output logic              lost_a,
  output logic              lost_b,
  output logic              err_a,
  output logic              err_b,
  output logic [15:0]       coll_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [DATA_W-1:0] r_rdata_a;
  logic [DATA_W-1:0] r_rdata_b;
  logic              r_rvalid_a;
  logic              r_rvalid_b;
  logic              r_lost_a;
  logic              r_lost_b;
  logic              r_err_a;
  logic              r_err_b;
  logic [15:0]       r_coll_cnt;
  logic              r_prio_b;

  logic w_act_a;
  logic w_act_b;
  logic w_err_a;
  logic w_err_b;
  logic w_same;
  logic w_coll;
  logic w_win_a;
  logic w_exe_a;
  logic w_exe_b;
  logic w_wen_a;
  logic w_wen_b;
  logic w_ren_a;
  logic w_ren_b;
  logic w_fwd_a;
  logic w_fwd_b;
  logic w_lost_a;
  logic w_lost_b;

  // A port is active only with exactly one of rd/wr; both is an error no-op.
  assign w_act_a = rd_a ^ wr_a;
  assign w_act_b = rd_b ^ wr_b;
  assign w_err_a = rd_a & wr_a;
  assign w_err_b = rd_b & wr_b;

  // Read/read on the same word is harmless, so it is not a collision.
  assign w_same = (addr_a == addr_b);
  assign w_coll = w_act_a & w_act_b & w_same & (wr_a | wr_b);

  // Fixed mode always favours A; round-robin follows the priority flag.
  assign w_win_a = (PRIO_MODE == 0) ? 1'b1 : ~r_prio_b;

  assign w_exe_a = w_act_a & (~w_coll | w_win_a);
  assign w_exe_b = w_act_b & (~w_coll | ~w_win_a);

  assign w_wen_a = w_exe_a & wr_a;
  assign w_wen_b = w_exe_b & wr_b;
  assign w_ren_a = w_exe_a & rd_a;
  assign w_ren_b = w_exe_b & rd_b;

`ifdef DUALPORT_RAM_ARB_FWD_EN
  // A losing reader sees the winning writer's data instead of being dropped.
  assign w_fwd_a = w_coll & ~w_win_a & wr_b & rd_a;
  assign w_fwd_b = w_coll &  w_win_a & wr_a & rd_b;
`else
  assign w_fwd_a = 1'b0;
  assign w_fwd_b = 1'b0;
`endif

  assign w_lost_a = w_act_a & w_coll & ~w_win_a & ~w_fwd_a;
  assign w_lost_b = w_act_b & w_coll &  w_win_a & ~w_fwd_b;

  // Memory array: never reset; writes are blocked while reset is high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_wen_a) begin
        r_mem[addr_a] <= wdata_a;
      end
      if (w_wen_b) begin
        r_mem[addr_b] <= wdata_b;
      end
    end
  end

  // Port A read data: read-first, holds value when no read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_a  <= '0;
      r_rvalid_a <= 1'b0;
    end else begin
      r_rvalid_a <= w_ren_a | w_fwd_a;
      if (w_fwd_a) begin
        r_rdata_a <= wdata_b;
      end else if (w_ren_a) begin
        r_rdata_a <= r_mem[addr_a];
      end
    end
  end

  // Port B read data: read-first, holds value when no read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata_b  <= '0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_b <= w_ren_b | w_fwd_b;
      if (w_fwd_b) begin
        r_rdata_b <= wdata_a;
      end else if (w_ren_b) begin
        r_rdata_b <= r_mem[addr_b];
      end
    end
  end

  // One-cycle status pulses for dropped and malformed requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lost_a <= 1'b0;
      r_lost_b <= 1'b0;
      r_err_a  <= 1'b0;
      r_err_b  <= 1'b0;
    end else begin
      r_lost_a <= w_lost_a;
      r_lost_b <= w_lost_b;
      r_err_a  <= w_err_a;
      r_err_b  <= w_err_b;
    end
  end

  // Priority hands over to the loser after every collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio_b <= 1'b0;
    end else if (w_coll && (PRIO_MODE == 1)) begin
      r_prio_b <= w_win_a;
    end
  end

  // Saturating collision counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll_cnt <= '0;
    end else if (w_coll && (r_coll_cnt != 16'hFFFF)) begin
      r_coll_cnt <= r_coll_cnt + 16'd1;
    end
  end

  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign lost_a   = r_lost_a;
  assign lost_b   = r_lost_b;
  assign err_a    = r_err_a;
  assign err_b    = r_err_b;
  assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_dualport_ram_arb.sv
// Bench for dualport_ram_arb: fixed-priority and round-robin
// instances driven in lockstep, checked against a scoreboard.
module tb_dualport_ram_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr_a, addr_b;
  logic       rd_a, rd_b, wr_a, wr_b;
  logic [7:0] wdata_a, wdata_b;

  logic [1:0][7:0]  rda, rdb;
  logic [1:0]       rva, rvb, loa, lob, era, erb;
  logic [1:0][15:0] cnt;

  typedef struct {
    logic [7:0]  rda;
    logic [7:0]  rdb;
    logic        rva;
    logic        rvb;
    logic        loa;
    logic        lob;
    logic        era;
    logic        erb;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];

  logic [7:0]  mm [2][16];
  logic        mprio [2];
  logic [15:0] mcnt [2];
  logic [7:0]  mrda [2];
  logic [7:0]  mrdb [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dualport_ram_arb #(.DATA_W(8), .ADDR_W(4), .PRIO_MODE(0)) u_fix (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .addr_b(addr_b),
    .rd_a(rd_a), .rd_b(rd_b), .wr_a(wr_a), .wr_b(wr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .rdata_a(rda[0]), .rdata_b(rdb[0]),
    .rvalid_a(rva[0]), .rvalid_b(rvb[0]),
    .lost_a(loa[0]), .lost_b(lob[0]),
    .err_a(era[0]), .err_b(erb[0]),
    .coll_cnt(cnt[0])
  );

  dualport_ram_arb #(.DATA_W(8), .ADDR_W(4), .PRIO_MODE(1)) u_rr (
    .clk(clk), .reset(reset),
    .addr_a(addr_a), .addr_b(addr_b),
    .rd_a(rd_a), .rd_b(rd_b), .wr_a(wr_a), .wr_b(wr_b),
    .wdata_a(wdata_a), .wdata_b(wdata_b),
    .rdata_a(rda[1]), .rdata_b(rdb[1]),
    .rvalid_a(rva[1]), .rvalid_b(rvb[1]),
    .lost_a(loa[1]), .lost_b(lob[1]),
    .err_a(era[1]), .err_b(erb[1]),
    .coll_cnt(cnt[1])
  );

  task automatic cmp(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst,
                      input logic ra, input logic wa,
                      input logic [3:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb,
                      input logic [3:0] ab, input logic [7:0] db,
                      input bit chk, input string tag);
    exp_t e;
    logic act_a, act_b, col, win_a, fa, fb;
    reset   = rst;
    rd_a    = ra;
    wr_a    = wa;
    addr_a  = aa;
    wdata_a = da;
    rd_b    = rb;
    wr_b    = wb;
    addr_b  = ab;
    wdata_b = db;
    for (int m = 0; m < 2; m++) begin
      e.rva = 1'b0; e.rvb = 1'b0;
      e.loa = 1'b0; e.lob = 1'b0;
      e.era = 1'b0; e.erb = 1'b0;
      if (rst) begin
        mprio[m] = 1'b0;
        mcnt[m]  = 16'h0;
        mrda[m]  = 8'h00;
        mrdb[m]  = 8'h00;
      end else begin
        act_a = (ra != wa);
        act_b = (rb != wb);
        col   = act_a && act_b && (aa == ab) && (wa || wb);
        win_a = (m == 0) || !mprio[m];
        fa = 1'b0;
        fb = 1'b0;
`ifdef DUALPORT_RAM_ARB_FWD_EN
        fb = col && win_a && wa && rb;
        fa = col && !win_a && wb && ra;
`endif
        e.era = ra && wa;
        e.erb = rb && wb;
        if (act_a && ra && (!col || win_a)) begin
          mrda[m] = mm[m][aa];
          e.rva = 1'b1;
        end else if (fa) begin
          mrda[m] = db;
          e.rva = 1'b1;
        end
        if (act_b && rb && (!col || !win_a)) begin
          mrdb[m] = mm[m][ab];
          e.rvb = 1'b1;
        end else if (fb) begin
          mrdb[m] = da;
          e.rvb = 1'b1;
        end
        e.loa = act_a && col && !win_a && !fa;
        e.lob = act_b && col && win_a && !fb;
        if (act_a && wa && (!col || win_a)) mm[m][aa] = da;
        if (act_b && wb && (!col || !win_a)) mm[m][ab] = db;
        if (col) begin
          if (mcnt[m] != 16'hFFFF) mcnt[m] = mcnt[m] + 16'd1;
          if (m == 1) mprio[m] = win_a;
        end
      end
      e.rda = mrda[m];
      e.rdb = mrdb[m];
      e.cnt = mcnt[m];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      e = q.pop_front();
      if (chk) begin
        cmp($sformatf("%s.m%0d.rdata_a", tag, m), 16'(rda[m]), 16'(e.rda));
        cmp($sformatf("%s.m%0d.rdata_b", tag, m), 16'(rdb[m]), 16'(e.rdb));
        cmp($sformatf("%s.m%0d.rvalid_a", tag, m), 16'(rva[m]), 16'(e.rva));
        cmp($sformatf("%s.m%0d.rvalid_b", tag, m), 16'(rvb[m]), 16'(e.rvb));
        cmp($sformatf("%s.m%0d.lost_a", tag, m), 16'(loa[m]), 16'(e.loa));
        cmp($sformatf("%s.m%0d.lost_b", tag, m), 16'(lob[m]), 16'(e.lob));
        cmp($sformatf("%s.m%0d.err_a", tag, m), 16'(era[m]), 16'(e.era));
        cmp($sformatf("%s.m%0d.err_b", tag, m), 16'(erb[m]), 16'(e.erb));
        cmp($sformatf("%s.m%0d.coll_cnt", tag, m), cnt[m], e.cnt);
      end
    end
  endtask

  task automatic idle(input logic rst, input string tag);
    step(rst, 0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, tag);
  endtask

  initial begin
    reset = 1'b1;
    rd_a = 0; rd_b = 0; wr_a = 0; wr_b = 0;
    addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;

    step(1, 0, 1, 4'd5, 8'hFF, 0, 0, 4'd0, 8'h00, 1'b1, "rst0");
    idle(1, "rst1");
    cmp("rst.cnt_fix", cnt[0], 16'h0);
    cmp("rst.rvalid_rr", 16'(rva[1]), 16'h0);

    step(0, 0, 1, 4'd0, 8'h10, 0, 1, 4'd4, 8'hAA, 1'b1, "init");

    step(0, 0, 1, 4'd2, 8'h01, 0, 1, 4'd2, 8'h02, 1'b1, "rr1");
    cmp("rr1.lost_b", 16'(lob[1]), 16'h1);
    step(0, 0, 1, 4'd2, 8'h03, 0, 1, 4'd2, 8'h04, 1'b1, "rr2");
    cmp("rr2.lost_a", 16'(loa[1]), 16'h1);
    step(0, 0, 1, 4'd2, 8'h05, 0, 1, 4'd2, 8'h06, 1'b1, "rr3");
    cmp("rr3.lost_b", 16'(lob[1]), 16'h1);
    step(0, 1, 0, 4'd2, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, "rr_rd");
    cmp("rr.mem2", 16'(rda[1]), 16'h05);
    cmp("rr.cnt", cnt[1], 16'h3);

    step(0, 0, 1, 4'd3, 8'h5A, 0, 0, 4'd0, 8'h00, 1'b1, "wr3");
    step(0, 0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00, 1'b1, "rd3");
    cmp("rd3.rdata_b", 16'(rdb[0]), 16'h5A);
    cmp("rd3.rvalid_b", 16'(rvb[0]), 16'h1);
    idle(0, "rd3_after");
    cmp("rd3.pulse_end", 16'(rvb[0]), 16'h0);

    step(0, 0, 1, 4'd7, 8'h11, 0, 1, 4'd7, 8'h22, 1'b1, "ww7");
    cmp("ww7.lost_b", 16'(lob[0]), 16'h1);
    step(0, 1, 0, 4'd7, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, "rd7");
    cmp("rd7.fix", 16'(rda[0]), 16'h11);
    cmp("rd7.lost_once", 16'(lob[0]), 16'h0);

    step(0, 0, 1, 4'd4, 8'hBB, 1, 0, 4'd4, 8'h00, 1'b1, "wr4");
`ifdef DUALPORT_RAM_ARB_FWD_EN
    cmp("wr4.rdata_b", 16'(rdb[0]), 16'hBB);
    cmp("wr4.rvalid_b", 16'(rvb[0]), 16'h1);
    cmp("wr4.lost_b", 16'(lob[0]), 16'h0);
`else
    cmp("wr4.rvalid_b", 16'(rvb[0]), 16'h0);
    cmp("wr4.lost_b", 16'(lob[0]), 16'h1);
`endif
    step(0, 1, 0, 4'd4, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, "rd4");
    cmp("rd4.mem", 16'(rda[0]), 16'hBB);

    step(0, 1, 1, 4'd0, 8'h77, 1, 0, 4'd0, 8'h00, 1'b1, "err0");
    cmp("err0.err_a", 16'(era[0]), 16'h1);
    cmp("err0.rdata_b", 16'(rdb[0]), 16'h10);
    step(0, 1, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, "rd0");
    cmp("rd0.mem", 16'(rda[0]), 16'h10);

    step(0, 1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, "pre_rst");
    step(1, 0, 1, 4'd3, 8'hEE, 1, 0, 4'd3, 8'h00, 1'b1, "mid_rst");
    cmp("mid_rst.rvalid_a", 16'(rva[0]), 16'h0);
    cmp("mid_rst.rdata_a", 16'(rda[0]), 16'h0);
    cmp("mid_rst.cnt", cnt[1], 16'h0);
    step(0, 1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00, 1'b1, "post_rst");
    cmp("post_rst.mem3", 16'(rda[0]), 16'h5A);

    for (int i = 0; i < 65540; i++) begin
      step(0, 0, 1, 4'd9, 8'(i), 0, 1, 4'd9, 8'(i + 1), 1'b0, "sat");
    end
    idle(0, "sat_end");
    cmp("sat.fix", cnt[0], 16'hFFFF);
    cmp("sat.rr", cnt[1], 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
